// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU datapath.
// Serves one load/store request at a time from a word-organised, big-endian,
// byte-addressed array. It inserts WAIT_CYCLES wait states before each legal
// access and merges sub-word stores through an internal read-modify-write.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   req_valid  request present
//   req_ready  responder idle; a request is accepted when req_valid && req_ready
//   req_write  1 = store, 0 = load
//   req_size   00 word, 01 halfword, 10 byte, 11 illegal
//   req_addr   byte address
//   req_wdata  store data; sub-word data is right-justified
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  load data, right-justified and zero-extended; 0 for stores and errors
//   rsp_err    qualifies rsp_valid: the request was rejected and the array is untouched
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    // WAIT holds for exactly WAIT_CYCLES cycles, so the counter starts one short.
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [1:0]  SZ_WORD    = 2'b00;
    localparam logic [1:0]  SZ_HALF    = 2'b01;
    localparam logic [1:0]  SZ_BYTE    = 2'b10;
    localparam logic [1:0]  SZ_BAD     = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, RMW, RESP} state_t;

    // Big-endian lane map: byte lane 0 is bits [31:24]; halfword 0 is bits [31:16].
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_shift = {~lane, 3'b000};
            SZ_HALF: lane_shift = lane[1] ? 5'd0 : 5'd16;
            default: lane_shift = 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_mask = 32'h0000_00FF;
            SZ_HALF: lane_mask = 32'h0000_FFFF;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                err_reg, err_next;
    logic                write_reg;
    logic [1:0]          size_reg;
    logic [IDX_W+1:0]    addr_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         rd_word_reg;
    logic [31:0]         rdata_hold_reg;
    logic                err_hold_reg;
    logic [31:0]         mem [DEPTH_WORDS];

    logic                handshake, illegal, acc_fire, acc_write, mem_we, rd_en;
    logic [1:0]          acc_size;
    logic [31:0]         acc_wdata, mem_wdata, merged, rsp_fresh;
    logic [IDX_W-1:0]    acc_idx, mem_widx;
    logic [4:0]          sh;
    logic [31:0]         mask;

    assign handshake = (state_reg == IDLE) && req_valid;
    assign illegal   = (req_size == SZ_BAD)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                    || (req_addr >= ADDR_LIMIT);

    // With no wait states the access happens on the handshake edge itself, so
    // it must take its operands straight from the request inputs.
    assign acc_write = (state_reg == IDLE) ? req_write : write_reg;
    assign acc_size  = (state_reg == IDLE) ? req_size  : size_reg;
    assign acc_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
    assign acc_idx   = (state_reg == IDLE) ? req_addr[IDX_W+1:2] : addr_reg[IDX_W+1:2];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        acc_fire   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        err_next = 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            acc_fire = 1'b1;
                        end else begin
                            cnt_next   = WAIT_LOAD;
                            state_next = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    acc_fire = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RMW:     state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (acc_fire) begin
            state_next = (acc_write && (acc_size != SZ_WORD)) ? RMW : RESP;
        end
    end

    // Lane selection always refers to the registered request (RMW and RESP).
    assign sh     = lane_shift(size_reg, addr_reg[1:0]);
    assign mask   = lane_mask(size_reg);
    assign merged = (rd_word_reg & ~(mask << sh)) | ((wdata_reg & mask) << sh);

    // Loads and sub-word stores read the array; word stores write it directly.
    assign rd_en     = acc_fire && !(acc_write && (acc_size == SZ_WORD));
    assign mem_we    = (acc_fire && acc_write && (acc_size == SZ_WORD)) || (state_reg == RMW);
    assign mem_widx  = (state_reg == RMW) ? addr_reg[IDX_W+1:2] : acc_idx;
    assign mem_wdata = (state_reg == RMW) ? merged : acc_wdata;

    // The array has no reset; gating on reset drops a write whose commit edge
    // coincides with reset.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_widx] <= mem_wdata;
        end
        if (rd_en && !reset) begin
            rd_word_reg <= mem[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            err_reg        <= 1'b0;
            write_reg      <= 1'b0;
            size_reg       <= SZ_WORD;
            addr_reg       <= '0;
            wdata_reg      <= 32'd0;
            rdata_hold_reg <= 32'd0;
            err_hold_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            if (handshake) begin
                write_reg <= req_write;
                size_reg  <= req_size;
                addr_reg  <= req_addr[IDX_W+1:0];
                wdata_reg <= req_wdata;
            end
            if (state_reg == RESP) begin
                rdata_hold_reg <= rsp_fresh;
                err_hold_reg   <= err_reg;
            end
        end
    end

    assign rsp_fresh = (err_reg || write_reg) ? 32'd0 : ((rd_word_reg >> sh) & mask);

    // Response fields show fresh values during RESP and keep them afterwards.
    assign req_ready = !reset && (state_reg == IDLE);
    assign rsp_valid = !reset && (state_reg == RESP);
    assign rsp_rdata = reset ? 32'd0 : ((state_reg == RESP) ? rsp_fresh : rdata_hold_reg);
    assign rsp_err   = !reset && ((state_reg == RESP) ? err_reg : err_hold_reg);
endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: one instance with no wait states and one with
// three wait states, driven by directed steps. Expected responses are queued
// when a request is issued and compared when the response pulse appears.
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [1:0]  req_size  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10, X = 2'b11;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge and return just after its handshake edge.
    task automatic issue(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input int el, input string tag);
        exp_t e;
        int   n;
        e.tag = tag; e.rdata = er; e.err = ee; e.lat = el;
        sb.push_back(e);
        @(negedge clk);
        req_valid[d] = 1'b1; req_write[d] = w; req_size[d] = sz;
        req_addr[d]  = a;    req_wdata[d] = wd;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
    endtask

    // Count cycles from the handshake to rsp_valid, then score the response.
    task automatic collect(input int d, input logic keep);
        exp_t e;
        int   lat;
        @(negedge clk);
        if (!keep) req_valid[d] = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_busy"}, 32'(req_ready[d]), 32'd0);
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        $display("dut%0d %s: lat=%0d rdata=%h err=%b", d, e.tag, lat, rsp_rdata[d], rsp_err[d]);
        check({e.tag, "_lat"},   32'(lat),           32'(e.lat));
        check({e.tag, "_rdata"}, rsp_rdata[d],       e.rdata);
        check({e.tag, "_err"},   32'(rsp_err[d]),    32'(e.err));
    endtask

    task automatic xfer(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int el, input string tag);
        issue(d, w, sz, a, wd, er, ee, el, tag);
        collect(d, 1'b0);
    endtask

    // Word store that is cut off by reset rst_at cycles after its handshake.
    task automatic reset_mid(input int d, input logic [31:0] a, input logic [31:0] wd, input int rst_at);
        @(negedge clk);
        req_valid[d] = 1'b1; req_write[d] = 1'b1; req_size[d] = W;
        req_addr[d]  = a;    req_wdata[d] = wd;
        check("rstmid_ready", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        for (int i = 1; i <= rst_at; i++) begin
            @(negedge clk);
            req_valid[d] = 1'b0;
            check("rstmid_no_rsp_pre", 32'(rsp_valid[d]), 32'd0);
        end
        reset[d] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rstmid_ready_in_reset", 32'(req_ready[d]), 32'd0);
            check("rstmid_valid_in_reset", 32'(rsp_valid[d]), 32'd0);
        end
        reset[d] = 1'b0;
        @(negedge clk);
        check("rstmid_ready_after", 32'(req_ready[d]), 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("rstmid_no_rsp_post", 32'(rsp_valid[d]), 32'd0);
        end
        $display("dut%0d reset_mid at T+%0d: store %h to %h dropped", d, rst_at, wd, a);
    endtask

    initial begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_size[d] = W; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_ready", 32'(req_ready[d]), 32'd0);
            check("reset_valid", 32'(rsp_valid[d]), 32'd0);
            check("reset_rdata", rsp_rdata[d],      32'd0);
            check("reset_err",   32'(rsp_err[d]),   32'd0);
        end
        reset[0] = 1'b0; reset[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("ready_after_reset", 32'(req_ready[d]), 32'd1);

        // No wait states.
        xfer(0, 1, W, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, "st_w10");
        xfer(0, 0, W, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1, "ld_w10");
        xfer(0, 1, W, 32'h20, 32'h11223344, 32'h0,        0, 1, "st_w20");
        xfer(0, 1, B, 32'h21, 32'h123456AA, 32'h0,        0, 2, "st_b21");
        xfer(0, 0, W, 32'h20, 32'h0,        32'h11AA3344, 0, 1, "ld_w20_b");
        xfer(0, 0, B, 32'h23, 32'h0,        32'h00000044, 0, 1, "ld_b23");
        xfer(0, 1, W, 32'h20, 32'h11223344, 32'h0,        0, 1, "st_w20b");
        xfer(0, 1, H, 32'h22, 32'h5555BEEF, 32'h0,        0, 2, "st_h22");
        xfer(0, 0, W, 32'h20, 32'h0,        32'h1122BEEF, 0, 1, "ld_w20_h");
        xfer(0, 0, H, 32'h20, 32'h0,        32'h00001122, 0, 1, "ld_h20");
        xfer(0, 0, H, 32'h22, 32'h0,        32'h0000BEEF, 0, 1, "ld_h22");
        xfer(0, 0, B, 32'h20, 32'h0,        32'h00000011, 0, 1, "ld_b20");

        // Errors: no array change, rdata forced to zero.
        xfer(0, 1, W, 32'h04,  32'hA5A5A5A5, 32'h0,        0, 1, "st_w04");
        xfer(0, 1, W, 32'h00,  32'h600DF00D, 32'h0,        0, 1, "st_w00");
        xfer(0, 0, W, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1, "ld_w10_b");
        xfer(0, 0, W, 32'h02,  32'h0,        32'h0,        1, 1, "err_ld_w02");
        xfer(0, 1, H, 32'h05,  32'h0000FFFF, 32'h0,        1, 1, "err_st_h05");
        xfer(0, 0, W, 32'h04,  32'h0,        32'hA5A5A5A5, 0, 1, "ld_w04");
        xfer(0, 1, X, 32'h10,  32'h12345678, 32'h0,        1, 1, "err_size");
        xfer(0, 0, W, 32'h10,  32'h0,        32'hDEADBEEF, 0, 1, "ld_w10_c");
        xfer(0, 1, W, 32'h100, 32'h0BADBAD0, 32'h0,        1, 1, "err_range");
        xfer(0, 0, W, 32'h00,  32'h0,        32'h600DF00D, 0, 1, "ld_w00");

        // Three wait states.
        xfer(1, 1, W, 32'h30, 32'h0BADF00D, 32'h0,        0, 4, "w3_st_w30");
        xfer(1, 0, W, 32'h30, 32'h0,        32'h0BADF00D, 0, 4, "w3_ld_w30");
        xfer(1, 1, B, 32'h31, 32'h000000EE, 32'h0,        0, 5, "w3_st_b31");
        xfer(1, 0, W, 32'h30, 32'h0,        32'h0BEEF00D, 0, 4, "w3_ld_w30_b");
        xfer(1, 1, X, 32'h30, 32'h0,        32'h0,        1, 1, "w3_err_size");

        // req_valid held high: re-accepted one cycle after rsp_valid.
        issue(1, 0, B, 32'h31, 32'h0, 32'h000000EE, 0, 4, "w3_held_a");
        collect(1, 1'b1);
        @(negedge clk);
        check("w3_held_reaccept", 32'(req_ready[1] && req_valid[1]), 32'd1);
        e.tag = "w3_held_b"; e.rdata = 32'h000000EE; e.err = 1'b0; e.lat = 4;
        sb.push_back(e);
        @(posedge clk);
        collect(1, 1'b0);

        // Reset mid-store, before and exactly on the commit edge.
        xfer(1, 1, W, 32'h40, 32'h01020304, 32'h0,        0, 4, "w3_st_w40");
        reset_mid(1, 32'h40, 32'hCAFEF00D, 2);
        xfer(1, 0, W, 32'h40, 32'h0,        32'h01020304, 0, 4, "w3_ld_w40_a");
        reset_mid(1, 32'h40, 32'hCAFEF00D, 3);
        xfer(1, 0, W, 32'h40, 32'h0,        32'h01020304, 0, 4, "w3_ld_w40_b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
